// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//
// UART receiver front-end. Deserialises an asynchronous serial line into
// parallel words using mid-bit sampling paced by a clock-cycle counter.
// Frame format: 1 start bit, WIDTH data bits (LSB first), no parity, 1 stop bit.
//
// Parameters:
//   WIDTH        data bits per frame (1..16)
//   CLKS_PER_BIT clk cycles per serial bit (even, >= 4)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   Rx         asynchronous serial line, idle high
//   Data_Out   last correctly framed word (stable between Out_rdy strobes)
//   Out_rdy    one-cycle strobe: Data_Out updated this cycle
//   Frame_err  one-cycle strobe: stop bit sampled low
//   Busy       high while a frame is in progress (state != IDLE)
// ---------------------------------------------------------------------------
module uart_rx_core #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Rx,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Out_rdy,
    output logic             Frame_err,
    output logic             Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(WIDTH + 1);

    // Counter compare points: half a bit to reach the centre of the start
    // bit, then whole bits to land in the centre of every following bit.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    logic             rx_meta_r;
    logic             rx_sync_r;
    logic [2:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0] bit_idx_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] data_out_r;
    logic             out_rdy_r;
    logic             frame_err_r;
    logic             busy_r;

    logic [2:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [IDX_W-1:0] bit_idx_nxt_s;
    logic [WIDTH-1:0] shift_nxt_s;
    logic [WIDTH-1:0] data_out_nxt_s;
    logic             out_rdy_nxt_s;
    logic             frame_err_nxt_s;

    // Two-flop synchroniser; resets to the idle (high) line level so a
    // quiet line never looks like a start bit after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= Rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Next-state and datapath decode for the receive FSM.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        bit_idx_nxt_s   = bit_idx_r;
        shift_nxt_s     = shift_r;
        data_out_nxt_s  = data_out_r;
        out_rdy_nxt_s   = 1'b0;
        frame_err_nxt_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s     = CNT_ZERO;
                bit_idx_nxt_s = IDX_ZERO;
                if (!rx_sync_r) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_nxt_s = CNT_ZERO;
                    // Still low at mid start bit: genuine frame. High means
                    // a glitch, dropped silently.
                    if (!rx_sync_r) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_nxt_s     = CNT_ZERO;
                    // Shift in from the top: after WIDTH samples the first
                    // (LSB) bit has arrived at bit 0.
                    shift_nxt_s   = (shift_r >> 1) | (WIDTH'(rx_sync_r) << (WIDTH - 1));
                    bit_idx_nxt_s = bit_idx_r + IDX_ONE;
                    if (bit_idx_r == LAST_IDX) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end

            ST_STOP: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_nxt_s = CNT_ZERO;
                    // Leaving in mid stop bit lets a back-to-back start bit
                    // be caught with no idle gap.
                    if (rx_sync_r) begin
                        data_out_nxt_s = shift_r;
                        out_rdy_nxt_s  = 1'b1;
                        state_nxt_s    = ST_IDLE;
                    end else begin
                        frame_err_nxt_s = 1'b1;
                        state_nxt_s     = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end

            ST_WAIT_IDLE: begin
                // Break or stuck-low line: hold here so a long low level
                // cannot spawn repeated frames.
                cnt_nxt_s = CNT_ZERO;
                if (rx_sync_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_IDLE;
                end
            end

            default: begin
                state_nxt_s   = ST_IDLE;
                cnt_nxt_s     = CNT_ZERO;
                bit_idx_nxt_s = IDX_ZERO;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            bit_idx_r   <= IDX_ZERO;
            shift_r     <= {WIDTH{1'b0}};
            data_out_r  <= {WIDTH{1'b0}};
            out_rdy_r   <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            bit_idx_r   <= bit_idx_nxt_s;
            shift_r     <= shift_nxt_s;
            data_out_r  <= data_out_nxt_s;
            out_rdy_r   <= out_rdy_nxt_s;
            frame_err_r <= frame_err_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    assign Data_Out  = data_out_r;
    assign Out_rdy   = out_rdy_r;
    assign Frame_err = frame_err_r;
    assign Busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
//
// Self-checking bench for uart_rx_core. Two instances: WIDTH=8/CLKS=8 and
// WIDTH=5/CLKS=4. Expected strobe times and data come from frame arithmetic:
// a strobe appears (WIDTH+1)*C + C/2 + 3 cycles after the start edge is
// driven, carrying the frame word (good stop) or the previous good word
// (bad stop).
// ---------------------------------------------------------------------------
module tb_uart_rx_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rx8;
    logic       rx5;
    logic [7:0] dout8;
    logic       rdy8, ferr8, busy8;
    logic [4:0] dout5;
    logic       rdy5, ferr5, busy5;

    uart_rx_core #(.WIDTH(8), .CLKS_PER_BIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .Rx(rx8),
        .Data_Out(dout8), .Out_rdy(rdy8), .Frame_err(ferr8), .Busy(busy8)
    );

    uart_rx_core #(.WIDTH(5), .CLKS_PER_BIT(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .Rx(rx5),
        .Data_Out(dout5), .Out_rdy(rdy5), .Frame_err(ferr5), .Busy(busy5)
    );

    typedef struct {
        int          sel;
        int          t;
        logic [1:0]  kind;      // {Out_rdy, Frame_err}
        logic [15:0] d;
        logic        busy;
        logic        busy_prev;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    logic [15:0] last_good [2];
    int          busy_cnt [2] = '{0, 0};
    int          stray [2]    = '{0, 0};
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    logic       busy8_p = 1'b0, busy5_p = 1'b0, rst_p = 1'b0;
    logic [7:0] dout8_p = 8'h00;
    logic [4:0] dout5_p = 5'h00;

    function automatic ev_t mk_ev(input int sel, input int t, input logic [1:0] k,
                                  input logic [15:0] d, input logic b, input logic bp);
        ev_t e;
        e.sel = sel; e.t = t; e.kind = k; e.d = d; e.busy = b; e.busy_prev = bp;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: logs strobes, counts busy cycles and unexpected Data_Out changes.
    always @(negedge clk) begin
        if (rdy8 || ferr8) obs_q.push_back(mk_ev(0, cyc, {rdy8, ferr8}, {8'h00, dout8}, busy8, busy8_p));
        if (rdy5 || ferr5) obs_q.push_back(mk_ev(1, cyc, {rdy5, ferr5}, {11'h000, dout5}, busy5, busy5_p));
        if (busy8) busy_cnt[0] <= busy_cnt[0] + 1;
        if (busy5) busy_cnt[1] <= busy_cnt[1] + 1;
        if (rst_n && rst_p && !rdy8 && (dout8 !== dout8_p)) stray[0] <= stray[0] + 1;
        if (rst_n && rst_p && !rdy5 && (dout5 !== dout5_p)) stray[1] <= stray[1] + 1;
        busy8_p <= busy8;
        busy5_p <= busy5;
        dout8_p <= dout8;
        dout5_p <= dout5;
        rst_p   <= rst_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_events(input string tag);
        chk({tag, "/count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, "/sel"},       obs_q[i].sel,       exp_q[i].sel);
            chk({tag, "/time"},      obs_q[i].t,         exp_q[i].t);
            chk({tag, "/kind"},      obs_q[i].kind,      exp_q[i].kind);
            chk({tag, "/data"},      obs_q[i].d,         exp_q[i].d);
            chk({tag, "/busy"},      obs_q[i].busy,      exp_q[i].busy);
            chk({tag, "/busy_prev"}, obs_q[i].busy_prev, exp_q[i].busy_prev);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // Drive one frame starting at the current negedge; leaves the line at the stop level.
    task automatic send_frame(input int sel, input logic [15:0] d, input logic stopb, input bit expect_evt);
        int          w, c, s;
        logic [15:0] dm;
        logic        v;
        w  = (sel == 0) ? 8 : 5;
        c  = (sel == 0) ? 8 : 4;
        dm = (sel == 0) ? (d & 16'h00ff) : (d & 16'h001f);
        s  = cyc;
        if (expect_evt) begin
            if (stopb) begin
                exp_q.push_back(mk_ev(sel, s + (w + 1) * c + c / 2 + 3, 2'b10, dm, 1'b0, 1'b1));
                last_good[sel] = dm;
            end else begin
                exp_q.push_back(mk_ev(sel, s + (w + 1) * c + c / 2 + 3, 2'b01, last_good[sel], 1'b1, 1'b1));
            end
        end
        for (int i = 0; i < w + 2; i++) begin
            if (i == 0)      v = 1'b0;
            else if (i <= w) v = dm[i-1];
            else             v = stopb;
            if (sel == 0) rx8 = v; else rx5 = v;
            repeat (c) @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic        sb;
        int          gap;

        rst_n = 1'b0;
        rx8   = 1'b1;
        rx5   = 1'b1;
        last_good[0] = 16'h0000;
        last_good[1] = 16'h0000;

        #1;
        chk("rst_dout8", dout8, 8'h00);
        chk("rst_rdy8",  rdy8,  1'b0);
        chk("rst_ferr8", ferr8, 1'b0);
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_dout5", dout5, 5'h00);
        chk("rst_busy5", busy5, 1'b0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_busy8", busy_cnt[0], 0);
        chk("idle_busy5", busy_cnt[1], 0);

        // Single frame 0xA5
        send_frame(0, 16'h00A5, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check_events("a5");
        chk("a5_dout", dout8, 8'hA5);

        // Back-to-back 0x00 then 0xFF, no idle gap
        send_frame(0, 16'h0000, 1'b1, 1'b1);
        send_frame(0, 16'h00FF, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check_events("b2b");
        chk("b2b_dout", dout8, 8'hFF);

        // Two-cycle low glitch: START lasts exactly half a bit, then rejected
        busy_cnt[0] = 0;
        rx8 = 1'b0;
        repeat (2) @(negedge clk);
        rx8 = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_busy_cycles", busy_cnt[0], 4);
        check_events("glitch");

        // Bad stop bit, then line held low (break)
        send_frame(0, 16'h003C, 1'b0, 1'b1);
        repeat (200) @(negedge clk);
        chk("break_busy_held", busy8, 1'b1);
        rx8 = 1'b1;
        repeat (2) @(negedge clk);
        chk("break_busy_lag", busy8, 1'b1);
        @(negedge clk);
        chk("break_busy_clear", busy8, 1'b0);
        repeat (5) @(negedge clk);
        check_events("ferr");
        chk("ferr_dout_kept", dout8, 8'hFF);
        chk("stray8_a", stray[0], 0);

        // Reset in the middle of data bit 4 of 0x81
        fork
            send_frame(0, 16'h0081, 1'b1, 1'b0);
            begin
                repeat (43) @(negedge clk);
                chk("pre_rst_busy", busy8, 1'b1);
                rst_n = 1'b0;
                #1;
                chk("midrst_dout", dout8, 8'h00);
                chk("midrst_busy", busy8, 1'b0);
                chk("midrst_rdy",  rdy8,  1'b0);
                chk("midrst_ferr", ferr8, 1'b0);
                repeat (45) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        last_good[0] = 16'h0000;
        busy_cnt[0]  = 0;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", busy_cnt[0], 0);
        check_events("rst");
        send_frame(0, 16'h0081, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check_events("rst_clean");
        chk("rst_clean_dout", dout8, 8'h81);

        // Random frames, random gaps, occasional bad stop bit (WIDTH=8)
        for (int i = 0; i < 10; i++) begin
            rd  = 16'($urandom);
            sb  = ($urandom_range(0, 3) != 0);
            send_frame(0, rd, sb, 1'b1);
            rx8 = 1'b1;
            gap = sb ? $urandom_range(0, 10) : $urandom_range(1, 10);
            repeat (gap) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check_events("rand8");
        chk("stray8_b", stray[0], 0);

        // WIDTH=5, CLKS_PER_BIT=4
        send_frame(1, 16'h0015, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check_events("w5");
        chk("w5_dout", dout5, 5'h15);

        for (int i = 0; i < 8; i++) begin
            rd  = 16'($urandom);
            sb  = ($urandom_range(0, 3) != 0);
            send_frame(1, rd, sb, 1'b1);
            rx5 = 1'b1;
            gap = sb ? $urandom_range(0, 6) : $urandom_range(1, 6);
            repeat (gap) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check_events("rand5");
        chk("stray5", stray[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
